// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART ASCII-hex command path: FSM state encoding and ASCII constants.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_AH,
    ST_W_AL,
    ST_W_DH,
    ST_W_DL,
    ST_W_EOL,
    ST_R_AH,
    ST_R_AL,
    ST_R_EOL,
    ST_DISCARD
  } state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_W    = 8'h57;
  localparam logic [7:0] ASCII_W_LC = 8'h77;
  localparam logic [7:0] ASCII_R    = 8'h52;
  localparam logic [7:0] ASCII_R_LC = 8'h72;

  // {valid, nibble} value for a byte that is not a hex digit
  localparam logic [4:0] HEX_INVALID = 5'b0_0000;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' -> {valid, nibble}.
module hex_ascii_decode
  import uart_cmd_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       valid,
  output logic [3:0] nibble
);

  // Letters A-F/a-f have low nibble 1..6, so adding 9 yields 10..15
  always_comb begin
    {valid, nibble} = HEX_INVALID;
    if (byte_in >= 8'h30 && byte_in <= 8'h39)
      {valid, nibble} = {1'b1, byte_in[3:0]};
    else if ((byte_in >= 8'h41 && byte_in <= 8'h46) ||
             (byte_in >= 8'h61 && byte_in <= 8'h66))
      {valid, nibble} = {1'b1, byte_in[3:0] + 4'd9};
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "W AH AL DH DL <EOL>" / "R AH AL <EOL>" ASCII hex lines into register strobes.
// Optional partial-line timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 CLK_10MHZ,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 wr_stb,
  output logic [7:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic                 rd_stb,
  output logic [7:0]           rd_addr,
  output logic                 err_stb,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  state_t     state;
  logic [7:0] addr_sh;
  logic [7:0] data_sh;
  logic       hex_valid;
  logic [3:0] nibble;
  logic       eol;
  logic       is_wr;
  logic       is_rd;
  logic       timeout_hit;
  logic       raise_err;

  hex_ascii_decode u_hex (
    .byte_in (rx_data),
    .valid   (hex_valid),
    .nibble  (nibble)
  );

  assign eol   = is_eol(rx_data);
  assign is_wr = (rx_data == ASCII_W) || (rx_data == ASCII_W_LC);
  assign is_rd = (rx_data == ASCII_R) || (rx_data == ASCII_R_LC);
  assign busy  = (state != ST_IDLE);

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] idle_cnt;

  always_ff @(posedge CLK_10MHZ) begin
    if (rst || rx_valid || state == ST_IDLE)
      idle_cnt <= '0;
    else if (idle_cnt != TO_LAST)
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout_hit = (state != ST_IDLE) && !rx_valid && (idle_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // One error per line: DISCARD never raises, and every error path lands in DISCARD or IDLE
  always_comb begin
    raise_err = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE:                    raise_err = !is_wr && !is_rd && !eol;
        ST_W_AH, ST_W_AL, ST_W_DH,
        ST_W_DL, ST_R_AH, ST_R_AL:  raise_err = !hex_valid;
        ST_W_EOL, ST_R_EOL:         raise_err = !eol;
        default:                    raise_err = 1'b0;
      endcase
    end else if (timeout_hit && state != ST_DISCARD) begin
      raise_err = 1'b1;
    end
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_sh <= '0;
      data_sh <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_stb  <= 1'b0;
      rd_addr <= '0;
      err_stb <= 1'b0;
      err_cnt <= '0;
    end else begin
      wr_stb  <= 1'b0;
      rd_stb  <= 1'b0;
      err_stb <= raise_err;
      if (raise_err && err_cnt != {ERR_CNT_W{1'b1}})
        err_cnt <= err_cnt + 1'b1;

      if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (is_wr)     state <= ST_W_AH;
            else if (is_rd) state <= ST_R_AH;
            else if (!eol)  state <= ST_DISCARD;
          end
          ST_W_AH, ST_W_AL, ST_W_DH, ST_W_DL, ST_R_AH, ST_R_AL: begin
            if (hex_valid) begin
              if (state == ST_W_DH || state == ST_W_DL)
                data_sh <= {data_sh[3:0], nibble};
              else
                addr_sh <= {addr_sh[3:0], nibble};
              case (state)
                ST_W_AH: state <= ST_W_AL;
                ST_W_AL: state <= ST_W_DH;
                ST_W_DH: state <= ST_W_DL;
                ST_W_DL: state <= ST_W_EOL;
                ST_R_AH: state <= ST_R_AL;
                default: state <= ST_R_EOL;
              endcase
            end else begin
              state <= eol ? ST_IDLE : ST_DISCARD;
            end
          end
          ST_W_EOL: begin
            if (eol) begin
              wr_addr <= addr_sh;
              wr_data <= data_sh;
              wr_stb  <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              state <= ST_DISCARD;
            end
          end
          ST_R_EOL: begin
            if (eol) begin
              rd_addr <= addr_sh;
              rd_stb  <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              state <= ST_DISCARD;
            end
          end
          default: begin
            if (eol) state <= ST_IDLE;
          end
        endcase
      end else if (timeout_hit) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser; timeout scenario checked according to CMD_TIMEOUT_EN.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_stb;
  logic [7:0] rd_addr;
  logic       err_stb;
  logic [7:0] err_cnt;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int err_seen = 0;
  int both_seen = 0;

  uart_cmd_parser #(.TIMEOUT_CYCLES(100), .ERR_CNT_W(8)) dut (
    .CLK_10MHZ (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_stb    (rd_stb),
    .rd_addr   (rd_addr),
    .err_stb   (err_stb),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  always #50 clk = ~clk;

  // Strobe tally, sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      wr_seen  += int'(wr_stb);
      rd_seen  += int'(rd_stb);
      err_seen += int'(err_stb);
      if (wr_stb && rd_stb) both_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int w0, r0, e0;

  initial begin
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    do_reset();
    check("rst_wr_stb", wr_stb, 0);
    check("rst_rd_stb", rd_stb, 0);
    check("rst_err_stb", err_stb, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_busy", busy, 0);

    // 1: basic write, strobe the cycle after CR
    w0 = wr_seen;
    send_str("W1A5C");
    check("t1_busy_mid", busy, 1);
    check("t1_no_early_wr", wr_seen - w0, 0);
    send_byte(8'h0D);
    check("t1_wr_stb", wr_stb, 1);
    check("t1_wr_addr", wr_addr, 8'h1A);
    check("t1_wr_data", wr_data, 8'h5C);
    @(negedge clk);
    check("t1_wr_stb_one_cycle", wr_stb, 0);
    check("t1_wr_count", wr_seen - w0, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_busy_after", busy, 0);

    // 2: lowercase read, CRLF counted as one EOL
    r0 = rd_seen; e0 = err_seen;
    send_str("r7f");
    send_byte(8'h0D);
    check("t2_rd_stb", rd_stb, 1);
    check("t2_rd_addr", rd_addr, 8'h7F);
    send_byte(8'h0A);
    check("t2_rd_count", rd_seen - r0, 1);
    check("t2_no_err", err_seen - e0, 0);
    check("t2_busy", busy, 0);
    check("t2_wr_addr_kept", wr_addr, 8'h1A);

    // 3: bad digit aborts, outputs unchanged, one error for the line
    w0 = wr_seen; e0 = err_seen;
    send_str("W1G");
    check("t3_err_stb_at_G", err_stb, 1);
    send_str("34");
    send_byte(8'h0D);
    check("t3_err_once", err_seen - e0, 1);
    check("t3_no_wr", wr_seen - w0, 0);
    check("t3_wr_addr_kept", wr_addr, 8'h1A);
    check("t3_wr_data_kept", wr_data, 8'h5C);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_busy", busy, 0);
    send_str("W0201");
    send_byte(8'h0A);
    check("t3_next_wr_stb", wr_stb, 1);
    check("t3_next_wr_addr", wr_addr, 8'h02);
    check("t3_next_wr_data", wr_data, 8'h01);

    // 4: short line, junk command, extra byte before EOL, lowercase hex
    send_str("W12");
    send_byte(8'h0D);
    check("t4_short_err_cnt", err_cnt, 2);
    check("t4_short_idle", busy, 0);
    send_str("X");
    send_byte(8'h0A);
    check("t4_junk_err_cnt", err_cnt, 3);
    w0 = wr_seen;
    send_str("W1A5CD");
    send_byte(8'h0D);
    check("t4_long_err_cnt", err_cnt, 4);
    check("t4_long_no_wr", wr_seen - w0, 0);
    check("t4_long_addr_kept", wr_addr, 8'h02);
    send_str("wabcd");
    send_byte(8'h0A);
    check("t4_lc_wr_addr", wr_addr, 8'hAB);
    check("t4_lc_wr_data", wr_data, 8'hCD);
    e0 = err_seen;
    for (int i = 0; i < 300; i++) begin
      send_str("X");
      send_byte(8'h0A);
    end
    check("t4_err_pulses", err_seen - e0, 300);
    check("t4_err_cnt_sat", err_cnt, 8'hFF);
    check("t4_never_both", both_seen, 0);

    // 5: reset mid-line
    send_str("W12");
    check("t5_busy_before", busy, 1);
    do_reset();
    check("t5_busy", busy, 0);
    check("t5_wr_addr", wr_addr, 0);
    check("t5_wr_data", wr_data, 0);
    check("t5_rd_addr", rd_addr, 0);
    check("t5_err_cnt", err_cnt, 0);
    w0 = wr_seen;
    send_str("34");
    send_byte(8'h0D);
    check("t5_err_cnt_after", err_cnt, 1);
    check("t5_no_wr", wr_seen - w0, 0);
    check("t5_busy_after", busy, 0);

    // 6: partial line then 100 idle clocks
    do_reset();
    e0 = err_seen;
    send_str("W1");
    repeat (101) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
    check("t6_timeout_err", err_seen - e0, 1);
    check("t6_timeout_idle", busy, 0);
    check("t6_timeout_cnt", err_cnt, 1);
`else
    check("t6_no_timeout_err", err_seen - e0, 0);
    check("t6_still_busy", busy, 1);
    check("t6_err_cnt", err_cnt, 0);
`endif
    send_byte(8'h0D);
    check("t6_idle_after_eol", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
